cla_result_checker: RTL and testbench
=====================================

// Module: cla_result_checker
// PURPOSE
//  Receiving end of the registered CLA adder output (Sum_out/Cout_out). Tracks every operand
//  set driven into the adder, predicts {Cout,Sum} and compares it to the adder output after
//  its pipeline latency. Counts passes and errors, captures the first failure, and can halt
//  on error. Used in benches and on-FPGA self-test beside CLA_with_DFF.
// PARAMETERS
//  WIDTH        4  operand/sum width in bits
//  LATENCY      1  adder latency in clocks, from operand sample edge to output valid; legal 1..8
//  CNT_W       16  width of the pass and error counters
//  STOP_ON_ERR  0  1 = enter HALT on the first mismatch
// PORTS
//  Clk         in   1          rising-edge clock, shared with the adder
//  Reset       in   1          synchronous, active-high; has priority over every other input
//  En          in   1          enable checking (IDLE<->CHECK)
//  Clear       in   1          synchronous clear of counters, error flag and capture regs
//  In_valid    in   1          A/B/Cin are a real operation this cycle
//  A           in   WIDTH      operand A, the same value the adder sees
//  B           in   WIDTH      operand B
//  Cin         in   1          carry-in
//  Sum_in      in   WIDTH      adder Sum_out
//  Cout_in     in   1          adder Cout_out
//  Chk_valid   out  1          one-cycle pulse: a comparison was performed
//  Mismatch    out  1          one-cycle pulse, qualified by Chk_valid: result was wrong
//  Err_flag    out  1          sticky: set by any mismatch
//  Err_count   out  CNT_W      saturating mismatch count
//  Pass_count  out  CNT_W      saturating match count
//  Err_exp     out  WIDTH+1    {Cout,Sum} expected at the first mismatch
//  Err_got     out  WIDTH+1    {Cout,Sum} received at the first mismatch
//  State       out  2          0=IDLE 1=CHECK 2=HALT
// BEHAVIOUR
//  Reset: all outputs 0, State=IDLE, all pipeline valid bits 0. Expected data regs are don't-care.
//  Prediction: exp = A + B + Cin, computed at WIDTH+1 bits; the MSB is Cout. Overflow cannot occur.
//  Pipeline: LATENCY stages of {valid, exp}. It shifts every clock, with no stall.
//   Stage 0 loads {In_valid, exp}. The pipeline loads in every state.
//  Timing: operands are sampled at edge N. Sum_in/Cout_in are sampled at edge N+LATENCY.
//   Chk_valid, Mismatch and the counters update at edge N+LATENCY, so they are visible in
//   the following cycle. Back-to-back operations give one check per cycle.
//  Compare: happens only when the tail valid bit is 1, State=CHECK and Reset=0.
//   Mismatch = ({Cout_in,Sum_in} != tail exp).
//  Counting: on a match, Pass_count+1; on a mismatch, Err_count+1 and Err_flag set.
//   Both counters saturate at 2^CNT_W-1.
//  Capture: Err_exp/Err_got load only on the first mismatch since Reset or Clear
//   (i.e. when Err_flag was 0); after that they hold.
//  FSM:
//   IDLE  -> CHECK when En=1.
//   CHECK -> IDLE when En=0.
//   CHECK -> HALT on a mismatch if STOP_ON_ERR=1; the mismatch that causes HALT is counted.
//   HALT: no compares, Chk_valid=0, counters and captures frozen.
//   HALT  -> (En ? CHECK : IDLE) on Clear.
//  Clear: zeroes counters, Err_flag, Err_exp and Err_got. Pipeline contents are kept.
//   If a compare falls in the same cycle as Clear, Clear wins and the compare is dropped.
//  Reset mid-operation: flushes all in-flight valids. No Chk_valid for LATENCY cycles after
//   release, which matches the adder's own register reset.
//  X on Sum_in/Cout_in while a compare is active counts as a mismatch (use !==-safe
//   logic, e.g. ^ reduction check).
// TESTING (WIDTH=4, LATENCY=1 unless noted)
//  A=1001 B=1101 Cin=0, Sum_in=0110 Cout_in=1 one edge later -> Chk_valid=1, Mismatch=0,
//   Pass_count=1.
//  A=0101 B=1010 Cin=0, force Sum_in=1110 Cout_in=0 -> Mismatch=1, Err_count=1, Err_flag=1,
//   Err_exp=01111, Err_got=01110.
//  CNT_W=2, 5 forced mismatches -> Err_count stays 3, Err_got holds the first failure only.
//  STOP_ON_ERR=1: 1 mismatch then 3 more bad results -> State=HALT, Err_count=1;
//   Clear with En=1 -> State=CHECK, counts 0.
//  LATENCY=3: 3 valid ops in flight, pulse Reset -> no Chk_valid for 3 cycles,
//   Pass_count=0, State=IDLE.
//  En=0 with 4 valid ops -> State=IDLE, Chk_valid never 1, counters 0.

Source files
------------

// File: rtl/cla_result_checker.sv
// Scoreboard for a registered CLA adder: predicts {Cout,Sum}, compares after LATENCY clocks, counts and captures errors.
// Latency: result checked LATENCY clocks after operands; no backpressure, one check per clock, pipeline never stalls.
module cla_result_checker #(
   parameter int WIDTH       = 4,
   parameter int LATENCY     = 1,
   parameter int CNT_W       = 16,
   parameter int STOP_ON_ERR = 0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic             Clear,
   input  logic             In_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic [WIDTH-1:0] Sum_in,
   input  logic             Cout_in,
   output logic             Chk_valid,
   output logic             Mismatch,
   output logic             Err_flag,
   output logic [CNT_W-1:0] Err_count,
   output logic [CNT_W-1:0] Pass_count,
   output logic [WIDTH:0]   Err_exp,
   output logic [WIDTH:0]   Err_got,
   output logic [1:0]       State
);

   localparam int EW = WIDTH + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t              state_q;
   logic [LATENCY-1:0]  vld_q;
   logic [LATENCY*EW-1:0] exp_q;
   logic                chk_q;
   logic                mism_q;
   logic                err_flag_q;
   logic [CNT_W-1:0]    err_cnt_q;
   logic [CNT_W-1:0]    pass_cnt_q;
   logic [EW-1:0]       err_exp_q;
   logic [EW-1:0]       err_got_q;

   logic [EW-1:0]       exp_d;
   logic [EW-1:0]       got_d;
   logic [EW-1:0]       tail_exp_d;
   logic [EW-1:0]       diff_d;
   logic                mism_d;
   logic                cmp_d;
   logic [LATENCY:0]    vld_ext_d;
   logic [(LATENCY+1)*EW-1:0] exp_ext_d;

   assign exp_d      = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
   assign got_d      = {Cout_in, Sum_in};
   assign tail_exp_d = exp_q[LATENCY*EW-1 -: EW];
   assign diff_d     = got_d ^ tail_exp_d;
   assign vld_ext_d  = {vld_q, In_valid};
   assign exp_ext_d  = {exp_q, exp_d};

   // An X/Z on the adder output makes the equality unknown, which falls to the else and flags it.
   always_comb begin
      mism_d = 1'b1;
      if (diff_d == '0) begin
         mism_d = 1'b0;
      end
   end

   assign cmp_d = vld_q[LATENCY-1] && (state_q == ST_CHECK) && !Clear;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_ext_d[LATENCY-1:0];
      end
   end

   always_ff @(posedge Clk) begin
      exp_q <= exp_ext_d[LATENCY*EW-1:0];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         chk_q      <= 1'b0;
         mism_q     <= 1'b0;
         err_flag_q <= 1'b0;
         err_cnt_q  <= '0;
         pass_cnt_q <= '0;
         err_exp_q  <= '0;
         err_got_q  <= '0;
      end else begin
         chk_q  <= cmp_d;
         mism_q <= cmp_d && mism_d;

         if (Clear) begin
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
            pass_cnt_q <= '0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
         end else if (cmp_d) begin
            if (mism_d) begin
               err_flag_q <= 1'b1;
               if (err_cnt_q != '1) begin
                  err_cnt_q <= err_cnt_q + CNT_ONE;
               end
               if (!err_flag_q) begin
                  err_exp_q <= tail_exp_d;
                  err_got_q <= got_d;
               end
            end else if (pass_cnt_q != '1) begin
               pass_cnt_q <= pass_cnt_q + CNT_ONE;
            end
         end

         // A halting mismatch wins over En dropping in the same cycle.
         case (state_q)
            ST_IDLE: begin
               if (En) state_q <= ST_CHECK;
            end
            ST_CHECK: begin
               if ((STOP_ON_ERR != 0) && cmp_d && mism_d) state_q <= ST_HALT;
               else if (!En) state_q <= ST_IDLE;
            end
            ST_HALT: begin
               if (Clear) state_q <= En ? ST_CHECK : ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign Chk_valid  = chk_q;
   assign Mismatch   = mism_q;
   assign Err_flag   = err_flag_q;
   assign Err_count  = err_cnt_q;
   assign Pass_count = pass_cnt_q;
   assign Err_exp    = err_exp_q;
   assign Err_got    = err_got_q;
   assign State      = state_q;

endmodule

// File: tb/tb_cla_result_checker.sv
// Bench: three checker configurations share operand stimulus; a cycle-level model per instance predicts every output.
module tb_cla_result_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en, clr, iv, cin;
   logic [3:0] a, b;
   logic [3:0] s_in [3];
   logic       c_in [3];

   logic        chk0, mm0, fl0, chk1, mm1, fl1, chk2, mm2, fl2;
   logic [15:0] ec0, pc0, ec1, pc1;
   logic [1:0]  ec2, pc2;
   logic [4:0]  ee0, eg0, ee1, eg1, ee2, eg2;
   logic [1:0]  st0, st1, st2;

   cla_result_checker #(.WIDTH(4), .LATENCY(1), .CNT_W(16), .STOP_ON_ERR(0)) u0 (
      .Clk(clk), .Reset(rst), .En(en), .Clear(clr), .In_valid(iv), .A(a), .B(b), .Cin(cin),
      .Sum_in(s_in[0]), .Cout_in(c_in[0]), .Chk_valid(chk0), .Mismatch(mm0), .Err_flag(fl0),
      .Err_count(ec0), .Pass_count(pc0), .Err_exp(ee0), .Err_got(eg0), .State(st0));

   cla_result_checker #(.WIDTH(4), .LATENCY(1), .CNT_W(16), .STOP_ON_ERR(1)) u1 (
      .Clk(clk), .Reset(rst), .En(en), .Clear(clr), .In_valid(iv), .A(a), .B(b), .Cin(cin),
      .Sum_in(s_in[1]), .Cout_in(c_in[1]), .Chk_valid(chk1), .Mismatch(mm1), .Err_flag(fl1),
      .Err_count(ec1), .Pass_count(pc1), .Err_exp(ee1), .Err_got(eg1), .State(st1));

   cla_result_checker #(.WIDTH(4), .LATENCY(3), .CNT_W(2), .STOP_ON_ERR(0)) u2 (
      .Clk(clk), .Reset(rst), .En(en), .Clear(clr), .In_valid(iv), .A(a), .B(b), .Cin(cin),
      .Sum_in(s_in[2]), .Cout_in(c_in[2]), .Chk_valid(chk2), .Mismatch(mm2), .Err_flag(fl2),
      .Err_count(ec2), .Pass_count(pc2), .Err_exp(ee2), .Err_got(eg2), .State(st2));

   function automatic int lat(input int k);
      return (k == 2) ? 3 : 1;
   endfunction
   function automatic int cmax(input int k);
      return (k == 2) ? 3 : 65535;
   endfunction
   function automatic bit stop(input int k);
      return (k == 1);
   endfunction

   // Model: per-edge history of true sums and per-instance op validity; outputs derived from the rules.
   logic [4:0] he [16];
   bit         hv [3][16];
   int         cyc = 0;
   bit         armed = 0;
   int         mst [3], mpass [3], merr [3];
   bit         mchk [3], mmm [3], mflag [3];
   logic [4:0] mce [3], mcg [3];
   int         nvec = 0, nerr = 0;

   always @(posedge clk) begin
      int e, ti;
      logic [4:0] got, ex;
      bit dcmp, bad;
      e = cyc;
      for (int k = 0; k < 3; k++) begin
         ti = (e - lat(k)) & 15;
         if (rst) begin
            for (int j = 0; j < lat(k); j++) hv[k][(e - j) & 15] = 1'b0;
            mst[k] = 0; mpass[k] = 0; merr[k] = 0;
            mchk[k] = 0; mmm[k] = 0; mflag[k] = 0; mce[k] = '0; mcg[k] = '0;
         end else begin
            got  = {c_in[k], s_in[k]};
            ex   = he[ti];
            dcmp = hv[k][ti] && (mst[k] == 1) && !clr;
            bad  = (got != ex);
            mchk[k] = dcmp;
            mmm[k]  = dcmp && bad;
            if (clr) begin
               mpass[k] = 0; merr[k] = 0; mflag[k] = 0; mce[k] = '0; mcg[k] = '0;
            end else if (dcmp && bad) begin
               if (!mflag[k]) begin mce[k] = ex; mcg[k] = got; end
               mflag[k] = 1;
               if (merr[k] < cmax(k)) merr[k] = merr[k] + 1;
            end else if (dcmp) begin
               if (mpass[k] < cmax(k)) mpass[k] = mpass[k] + 1;
            end
            if (mst[k] == 0) begin
               if (en) mst[k] = 1;
            end else if (mst[k] == 1) begin
               if (stop(k) && dcmp && bad) mst[k] = 2;
               else if (!en) mst[k] = 0;
            end else if (clr) begin
               mst[k] = en ? 1 : 0;
            end
            hv[k][e & 15] = iv;
         end
      end
      he[e & 15] = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      if (rst) armed = 1;
      cyc = e + 1;
   end

   task automatic cmp(input int k, input logic chk, mm, fl, input logic [15:0] ec, pc,
                      input logic [4:0] ee, eg, input logic [1:0] st);
      nvec++;
      if (chk !== mchk[k] || mm !== mmm[k] || fl !== mflag[k] || ec != 16'(merr[k]) ||
          pc != 16'(mpass[k]) || ee !== mce[k] || eg !== mcg[k] || st != 2'(mst[k])) begin
         nerr++;
         $display("FAIL model u%0d cyc=%0d got chk=%b mm=%b flag=%b err=%0d pass=%0d exp=%b got=%b st=%0d want chk=%b mm=%b flag=%b err=%0d pass=%0d exp=%b got=%b st=%0d",
                  k, cyc, chk, mm, fl, ec, pc, ee, eg, st,
                  mchk[k], mmm[k], mflag[k], merr[k], mpass[k], mce[k], mcg[k], mst[k]);
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         cmp(0, chk0, mm0, fl0, ec0, pc0, ee0, eg0, st0);
         cmp(1, chk1, mm1, fl1, ec1, pc1, ee1, eg1, st1);
         cmp(2, chk2, mm2, fl2, {14'b0, ec2}, {14'b0, pc2}, ee2, eg2, st2);
      end
   end

   task automatic lit(input string nm, input int got, input int want);
      nvec++;
      if (got != want) begin
         nerr++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   // Drive one clock of stimulus; masks corrupt the adder result presented to each instance.
   task automatic cyc_t(input bit r, e_, c, v, input logic [3:0] aa, bb, input logic ci,
                        input logic [4:0] m0, m1, m2);
      logic [4:0] mk;
      rst = r; en = e_; clr = c; iv = v; a = aa; b = bb; cin = ci;
      for (int k = 0; k < 3; k++) begin
         mk = (k == 0) ? m0 : (k == 1) ? m1 : m2;
         {c_in[k], s_in[k]} = he[(cyc - lat(k)) & 15] ^ mk;
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) he[i] = '0;
      for (int i = 0; i < 3; i++) cyc_t(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      lit("rst state", st0, 0);
      lit("rst chk", chk0, 0);
      lit("rst pass", pc0, 0);
      lit("rst err", ec0, 0);
      lit("rst flag", fl0, 0);
      lit("rst errexp", ee0, 0);

      cyc_t(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      lit("idle to check", st0, 1);

      cyc_t(0, 1, 0, 1, 4'b1001, 4'b1101, 0, 0, 0, 0);
      cyc_t(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      lit("pass chk", chk0, 1);
      lit("pass mm", mm0, 0);
      lit("pass count", pc0, 1);
      lit("model pass", mpass[0], 1);

      cyc_t(0, 1, 0, 1, 4'b0101, 4'b1010, 0, 0, 0, 0);
      cyc_t(0, 1, 0, 0, 0, 0, 0, 5'h01, 5'h01, 5'h00);
      lit("mm pulse", mm0, 1);
      lit("mm errcount", ec0, 1);
      lit("mm flag", fl0, 1);
      lit("mm errexp", ee0, 5'b01111);
      lit("mm errgot", eg0, 5'b01110);
      lit("model errexp", mce[0], 5'b01111);
      lit("halt state", st1, 2);

      for (int i = 0; i < 4; i++) cyc_t(0, 1, 0, (i < 3), 3, 4, 1, 0, 5'h10, 0);
      lit("halt state held", st1, 2);
      lit("halt errcount", ec1, 1);
      lit("halt pass frozen", pc1, 1);

      cyc_t(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      lit("clear to check", st1, 1);
      lit("clear errcount", ec1, 0);
      lit("clear pass", pc1, 0);
      lit("clear flag", fl1, 0);

      for (int i = 0; i < 3; i++) cyc_t(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++)
         cyc_t(0, 1, 0, (i < 5), 4'(i + 1), 4'd2, 0, 0, 0, (i >= 3) ? 5'h01 : 5'h00);
      lit("sat errcount", ec2, 3);
      lit("sat errgot first", eg2, 5'b00010);
      lit("sat errexp first", ee2, 5'b00011);
      lit("model sat", merr[2], 3);

      for (int i = 0; i < 3; i++) cyc_t(0, 1, 0, 1, 7, 8, 1, 0, 0, 0);
      cyc_t(1, 1, 0, 1, 7, 8, 1, 0, 0, 0);
      lit("lat3 rst state", st2, 0);
      lit("lat3 rst pass", pc2, 0);
      lit("lat3 rst chk", chk2, 0);
      for (int i = 0; i < 3; i++) begin
         cyc_t(0, 1, 0, 1, 4'(i), 4'(i), 0, 0, 0, 0);
         lit("lat3 flushed chk", chk2, 0);
      end
      cyc_t(0, 1, 0, 1, 2, 2, 0, 0, 0, 0);
      lit("lat3 first chk", chk2, 1);

      cyc_t(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc_t(0, 0, 0, 1, 4'(i), 4'(i + 3), 1, 0, 0, 0);
         lit("en0 chk", {chk0, chk1, chk2}, 0);
      end
      lit("en0 state", st0, 0);
      lit("en0 pass", pc0, 0);
      lit("en0 err", ec0, 0);

      for (int n = 0; n < 3000; n++) begin
         logic [4:0] m [3];
         for (int k = 0; k < 3; k++)
            m[k] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'h00;
         cyc_t($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 92, $urandom_range(0, 99) < 3,
               $urandom_range(0, 99) < 75, 4'($urandom), 4'($urandom), 1'($urandom),
               m[0], m[1], m[2]);
      end
      cyc_t(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
